// File: rtl/des_round_f_serial.sv
// Serial DES round function f(R,K): E-expansion and key XOR, eight S-box lookups
// through one shared S-box over eight cycles, then the P permutation.

module des_sbox (
  input  logic [5:0] s_in,
  input  logic [2:0] box_num,
  output logic [3:0] s_out
);
  // 32 rows of 16 nibbles, S1 row 0 first; entry (box,row,col) is nibble box*64+row*16+col from the MSB
  localparam logic [2047:0] SBOX_TBL = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175BE3A06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  logic [8:0]  addr;
  logic [10:0] bit_hi;

  // row is the outer bit pair of the chunk, column the middle four
  assign addr   = {box_num, s_in[5], s_in[0], s_in[4:1]};
  assign bit_hi = 11'd2047 - {addr, 2'b00};
  assign s_out  = SBOX_TBL[bit_hi -: 4];
endmodule

module des_round_f_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f_out,
  output logic        busy,
  output logic [1:0]  dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid && ready; a producer
  // holds valid and data stable until that edge, ready never depends on valid.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [47:0] x_reg;
  logic [31:0] cat_reg;
  logic [33:0] r_wrap;
  logic [47:0] e_val;
  logic [5:0]  s_in;
  logic [3:0]  s_out;

  // DES bit 32 ahead of bit 1 and bit 1 after bit 32, so each E chunk is a contiguous slice
  assign r_wrap = {r_in[0], r_in, r_in[31]};

  always_comb begin
    e_val = '0;
    for (int i = 0; i < 8; i++) begin
      e_val[47-6*i -: 6] = r_wrap[33-4*i -: 6];
    end
  end

  always_comb begin
    s_in = '0;
    for (int i = 0; i < 8; i++) begin
      if (cnt == 3'(i)) s_in = x_reg[47-6*i -: 6];
    end
  end

  des_sbox u_sbox (
    .s_in    (s_in),
    .box_num (cnt),
    .s_out   (s_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = (in_valid) ? SUB : IDLE;
      SUB:     state_nxt = (cnt == 3'd7) ? DONE : SUB;
      DONE:    state_nxt = (out_ready) ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == SUB) || (state == DONE);
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      x_reg   <= '0;
      cat_reg <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        x_reg   <= e_val ^ subkey;
        cnt     <= '0;
        cat_reg <= '0;
      end
    end else if (state == SUB) begin
      for (int i = 0; i < 8; i++) begin
        if (cnt == 3'(i)) cat_reg[31-4*i -: 4] <= s_out;
      end
      cnt <= cnt + 3'd1;
    end
  end

  // P permutation; cat_reg is frozen outside SUB so f_out holds through backpressure
  assign f_out = {cat_reg[16], cat_reg[25], cat_reg[12], cat_reg[11],
                  cat_reg[3],  cat_reg[20], cat_reg[4],  cat_reg[15],
                  cat_reg[31], cat_reg[17], cat_reg[9],  cat_reg[6],
                  cat_reg[27], cat_reg[14], cat_reg[1],  cat_reg[22],
                  cat_reg[30], cat_reg[24], cat_reg[8],  cat_reg[18],
                  cat_reg[0],  cat_reg[5],  cat_reg[29], cat_reg[23],
                  cat_reg[13], cat_reg[19], cat_reg[2],  cat_reg[26],
                  cat_reg[10], cat_reg[21], cat_reg[28], cat_reg[7]};
endmodule

// File: doc/des_round_f_serial.md
Name: des_round_f_serial

Overview:
- Serial DES round function f(R, K), sitting directly upstream of the SBox stage.
- Expands the 32-bit right half to 48 bits (DES E table) and XORs it with the 48-bit round subkey.
- Drives one shared SBox instance for 8 consecutive cycles (box_num 0..7), collects the 4-bit results and applies the DES P permutation.
- Uses valid/ready handshakes on both input and output; the Feistel round controller feeds it.

Parameters:
- None. All widths are fixed by DES: R 32, K 48, f 32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  r_in/subkey valid
- in_ready  output  1  block can accept; high only in IDLE
- r_in  input  32  right half; r_in[31] = DES bit 1
- subkey  input  48  round key; subkey[47] = DES bit 1
- out_valid  output  1  f_out valid; held until accepted
- out_ready  input  1  consumer accepts f_out
- f_out  output  32  P(S(E(r_in) ^ subkey)); f_out[31] = DES bit 1
- busy  output  1  high in SUB or DONE

Behaviour:
- **Bit order.** DES bit n of a w-bit vector is vector[w-n].
  - E and P follow FIPS 46-3 tables exactly.
  - Chunk i (0..7) of the 48-bit XOR register is x_reg[47-6i -: 6], fed as SBox s_in with box_num = i.
  - SBox output i lands in cat_reg[31-4i -: 4].
- **Internal SBox.** The block instantiates SBox internally: s_in 6 bits, box_num 3 bits, s_out 4 bits, purely combinational.
- **States:** IDLE, SUB, DONE (2-bit encoding; unused encoding returns to IDLE).
- **IDLE.**
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready at an edge:
    - x_reg <= E(r_in) ^ subkey.
    - cnt <= 0.
    - cat_reg <= 0.
    - Go to SUB.
- **SUB.**
  - in_ready=0.
  - Each edge: cat_reg[31-4*cnt -: 4] <= s_out for box cnt; cnt <= cnt+1.
  - At the edge where cnt==7, go to DONE; cnt wraps to 0.
- **DONE.**
  - out_valid=1; f_out = P(cat_reg) (combinational from the register, or registered on entry; must be stable while out_valid).
  - On out_valid & out_ready, go to IDLE.
  - f_out must not change while out_valid=1 && out_ready=0.
- **Latency.** out_valid rises exactly 8 clocks after the input handshake edge.
- **Throughput.**
  - Minimum 10 cycles per operation: 8 SUB, 1 DONE with out_ready=1, 1 IDLE.
  - in_ready is never asserted in DONE.
- **Reset values:** state=IDLE, cnt=0, x_reg=0, cat_reg=0, in_ready=1 (after reset release, state IDLE), out_valid=0, busy=0, f_out=P(0)=0.
- **Inputs while busy.** in_valid while in_ready=0 is ignored; inputs are sampled only at the handshake edge, so r_in/subkey may change freely afterwards.
- **Reset mid-operation.** rst_n low in SUB or DONE aborts immediately and asynchronously: all registers take reset values, no out_valid pulse, no partial result.
- **out_ready.** Ignored outside DONE.
- **X-safety.** No X must propagate to out_valid/in_ready when in_valid is low.

Test Plan:
- **Standard DES round-1 vector.** r_in=0xF0AAF0AA, subkey=0x1B02EFFC7072 -> after 8 clocks out_valid=1; intermediate x_reg=0x6117BA866527, cat_reg=0x5C82B597; f_out=0x234AA9BB.
- **All-zero inputs.** r_in=0, subkey=0 -> cat_reg=0xEFA72C4D, f_out=0xD8D8DBBC.
- **Output backpressure.** Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, f_out constant, in_ready stays 0; out_ready=1 -> next cycle out_valid=0, in_ready=1.
- **Busy-input rejection.** Hold in_valid=1 with a different r_in throughout SUB -> in_ready=0 and the result still equals the first operation's f.
- **Reset mid-operation.** Assert rst_n=0 at cnt=4 -> in_ready=1, out_valid=0, busy=0 with no clock edge required; the next operation (vector 1) produces 0x234AA9BB.
- **Back-to-back operations.** Keep out_ready=1 and in_valid=1 and run vector 1 then vector 2 -> handshakes are 10 cycles apart; results 0x234AA9BB then 0xD8D8DBBC in order.
